// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants, channel state type and divisor helper for pio_clkdiv
package pio_pkg;

    localparam int NUM_SM        = 4;
    localparam int CLKDIV_INT_W  = 16;
    localparam int CLKDIV_FRAC_W = 8;
    localparam int CLKDIV_W      = CLKDIV_INT_W + CLKDIV_FRAC_W;
    localparam int CLKDIV_CNT_W  = CLKDIV_INT_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pio_state_e;

    // An integer divisor of zero stands for the full 2^16 period.
    function automatic logic [CLKDIV_CNT_W-1:0] clkdiv_int_eff(input logic [CLKDIV_INT_W-1:0] div_int);
        if (div_int == '0) begin
            return {1'b1, {CLKDIV_INT_W{1'b0}}};
        end
        return {1'b0, div_int};
    endfunction

endpackage

// File: rtl/pio_clkdiv_ch.sv
// rtl/pio_clkdiv_ch.sv - one clock-divider channel; fractional accumulator under PIO_CLKDIV_FRAC_EN
module pio_clkdiv_ch
    import pio_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     restart,
    input  logic [CLKDIV_INT_W-1:0]  div_int,
    input  logic [CLKDIV_FRAC_W-1:0] div_frac,
    output logic                     tick,
    output logic                     running
);

    localparam logic [CLKDIV_CNT_W-1:0] CNT_ONE = CLKDIV_CNT_W'(1);

    pio_state_e              r_state;
    logic [CLKDIV_CNT_W-1:0] r_cnt;
    logic                    r_tick;

    logic [CLKDIV_CNT_W-1:0] w_cnt_cur;
    logic [CLKDIV_CNT_W-1:0] w_reload;
    logic                    w_carry;
    logic                    w_expire;

    // A restart behaves as if the period had just ended with a cleared accumulator.
    assign w_cnt_cur = restart ? CNT_ONE : r_cnt;
    assign w_expire  = (w_cnt_cur == CNT_ONE);

`ifdef PIO_CLKDIV_FRAC_EN
    logic [CLKDIV_FRAC_W-1:0] r_acc;
    logic [CLKDIV_FRAC_W-1:0] w_acc_cur;
    logic [CLKDIV_FRAC_W-1:0] w_frac_eff;
    logic [CLKDIV_FRAC_W-1:0] w_acc_next;

    assign w_acc_cur                = restart ? '0 : r_acc;
    assign w_frac_eff               = (div_int == '0) ? '0 : div_frac;
    assign {w_carry, w_acc_next}    = {1'b0, w_acc_cur} + {1'b0, w_frac_eff};
`else
    logic w_unused_frac;

    assign w_unused_frac = ^div_frac;
    assign w_carry       = 1'b0;
`endif

    assign w_reload = clkdiv_int_eff(div_int) + {{(CLKDIV_CNT_W-1){1'b0}}, w_carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ONE;
            r_tick  <= 1'b0;
`ifdef PIO_CLKDIV_FRAC_EN
            r_acc   <= '0;
`endif
        end else if (!en) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ONE;
            r_tick  <= 1'b0;
`ifdef PIO_CLKDIV_FRAC_EN
            r_acc   <= '0;
`endif
        end else begin
            r_state <= RUN;
            r_tick  <= w_expire;
            if (w_expire) begin
                r_cnt <= w_reload;
`ifdef PIO_CLKDIV_FRAC_EN
                r_acc <= w_acc_next;
`endif
            end else begin
                r_cnt <= w_cnt_cur - CNT_ONE;
            end
        end
    end

    assign tick    = r_tick;
    assign running = (r_state == RUN);

endmodule

// File: rtl/pio_clkdiv.sv
// rtl/pio_clkdiv.sv - NUM_SM independent PIO clock dividers; PIO_CLKDIV_FRAC_EN enables fractional division
module pio_clkdiv #(
    parameter int NUM_SM = pio_pkg::NUM_SM
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SM-1:0]                     sm_en,
    input  logic [NUM_SM-1:0]                     clkdiv_restart,
    input  logic [NUM_SM-1:0][pio_pkg::CLKDIV_W-1:0] fsm_clkdiv,
    output logic [NUM_SM-1:0]                     tick,
    output logic [NUM_SM-1:0]                     running
);

    import pio_pkg::*;

    // Each 24-bit slice is CLKDIV register bits [31:8]: INT in [23:8], FRAC in [7:0].
    for (genvar g = 0; g < NUM_SM; g++) begin : g_ch
        logic [CLKDIV_INT_W-1:0]  w_int;
        logic [CLKDIV_FRAC_W-1:0] w_frac;

        assign w_int  = fsm_clkdiv[g][CLKDIV_W-1:CLKDIV_FRAC_W];
        assign w_frac = fsm_clkdiv[g][CLKDIV_FRAC_W-1:0];

        pio_clkdiv_ch u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (sm_en[g]),
            .restart  (clkdiv_restart[g]),
            .div_int  (w_int),
            .div_frac (w_frac),
            .tick     (tick[g]),
            .running  (running[g])
        );
    end

endmodule

// File: tb/tb_pio_clkdiv.sv
// tb/tb_pio_clkdiv.sv - directed self-checking bench for pio_clkdiv
module tb_pio_clkdiv;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       sm_en;
    logic [3:0]       clkdiv_restart;
    logic [3:0][23:0] fsm_clkdiv;
    logic [3:0]       tick;
    logic [3:0]       running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]     int_v;
        logic [7:0]      frac_v;
        logic [4:0][7:0] exp_t;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    pio_clkdiv #(.NUM_SM(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .sm_en          (sm_en),
        .clkdiv_restart (clkdiv_restart),
        .fsm_clkdiv     (fsm_clkdiv),
        .tick           (tick),
        .running        (running)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        sm_en[0] = 1'b0;
        @(negedge clk);
        fsm_clkdiv[0] = {v.int_v, v.frac_v};
        @(negedge clk);
        check($sformatf("vec%0d idle tick", idx), {31'd0, tick[0]}, 32'd0);
        sm_en[0] = 1'b1;
        n = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (tick[0] && n < 5) begin
                check($sformatf("vec%0d tick%0d time", idx, n), c, {24'd0, v.exp_t[n]});
                n++;
            end
        end
        check($sformatf("vec%0d tick count", idx), n, 32'd5);
    endtask

    initial begin
        int          n;
        int          t0;
        int          t1;
        int          rs_times [6];
        logic [31:0] rs_exp [6];

        vecs[0] = '{16'd1, 8'h00, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}};
        vecs[1] = '{16'd3, 8'h00, {8'd13, 8'd10, 8'd7, 8'd4, 8'd1}};
        vecs[3] = '{16'd5, 8'h00, {8'd21, 8'd16, 8'd11, 8'd6, 8'd1}};
`ifdef PIO_CLKDIV_FRAC_EN
        vecs[2] = '{16'd1, 8'h80, {8'd7, 8'd5, 8'd4, 8'd2, 8'd1}};
        vecs[4] = '{16'd2, 8'h40, {8'd10, 8'd7, 8'd5, 8'd3, 8'd1}};
        vecs[5] = '{16'd3, 8'hFF, {8'd16, 8'd12, 8'd8, 8'd4, 8'd1}};
`else
        vecs[2] = '{16'd1, 8'h80, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}};
        vecs[4] = '{16'd2, 8'h40, {8'd9, 8'd7, 8'd5, 8'd3, 8'd1}};
        vecs[5] = '{16'd3, 8'hFF, {8'd13, 8'd10, 8'd7, 8'd4, 8'd1}};
`endif

        rst            = 1'b1;
        sm_en          = 4'h0;
        clkdiv_restart = 4'h0;
        fsm_clkdiv     = '0;
        #1;
        check("reset tick", {28'd0, tick}, 32'd0);
        check("reset running", {28'd0, running}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        check("run running", {31'd0, running[0]}, 32'd1);
        sm_en[0] = 1'b0;
        @(negedge clk);
        check("disable tick", {31'd0, tick[0]}, 32'd0);
        check("disable running", {31'd0, running[0]}, 32'd0);

        // Restart mid-period, then a divisor change that waits for the next reload.
        fsm_clkdiv[0] = {16'd10, 8'h00};
        @(negedge clk);
        sm_en[0] = 1'b1;
        rs_exp = '{32'd1, 32'd7, 32'd17, 32'd27, 32'd31, 32'd35};
        n = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (tick[0] && n < 6) begin
                rs_times[n] = c;
                n++;
            end
            clkdiv_restart[0] = (c == 6);
            if (c == 20) fsm_clkdiv[0] = {16'd4, 8'h00};
        end
        check("restart tick count", n, 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < n) check($sformatf("restart tick%0d time", k), rs_times[k], rs_exp[k]);
        end

        clkdiv_restart[1] = 1'b1;
        @(negedge clk);
        clkdiv_restart[1] = 1'b0;
        check("restart idle tick", {31'd0, tick[1]}, 32'd0);
        @(negedge clk);
        check("restart idle tick2", {31'd0, tick[1]}, 32'd0);
        check("restart idle running", {31'd0, running[1]}, 32'd0);

        // INT=0 means a 65536-cycle period, regardless of FRAC.
        sm_en = 4'h0;
        @(negedge clk);
        fsm_clkdiv[0] = {16'd0, 8'h00};
        fsm_clkdiv[1] = {16'd0, 8'hFF};
        @(negedge clk);
        sm_en = 4'h3;
        t0 = 0;
        t1 = 0;
        for (int c = 1; c <= 65540; c++) begin
            @(negedge clk);
            if (c == 1) check("int0 first tick", {30'd0, tick[1:0]}, 32'd3);
            if (c > 1 && tick[0] && t0 == 0) t0 = c;
            if (c > 1 && tick[1] && t1 == 0) t1 = c;
        end
        check("int0 frac0 second tick", t0, 32'd65537);
        check("int0 fracff second tick", t1, 32'd65537);

        // Asynchronous reset mid-period across all channels.
        sm_en = 4'h0;
        @(negedge clk);
        fsm_clkdiv[0] = {16'd1, 8'h00};
        fsm_clkdiv[1] = {16'd5, 8'h00};
        fsm_clkdiv[2] = {16'd7, 8'h00};
        fsm_clkdiv[3] = {16'd10, 8'h00};
        sm_en = 4'hF;
        repeat (4) @(negedge clk);
        check("pre-reset tick", {28'd0, tick}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid reset tick", {28'd0, tick}, 32'd0);
        check("mid reset running", {28'd0, running}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post reset first tick", {28'd0, tick}, 32'hF);
        check("post reset running", {28'd0, running}, 32'hF);
        @(negedge clk);
        check("post reset second tick", {28'd0, tick}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
